// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard and sequencing controller for a 5-stage RISC-V pipeline.
// It generates per-stage stall/flush strobes and EX-stage forwarding selects.
// It holds the front of the pipeline while a multi-cycle mul/div occupies EX.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   defined     : stall_cnt / flush_cnt are live wrapping perf counters
//   not defined : stall_cnt / flush_cnt are tied to zero (no counter flops)
//
// Parameters
//   MULDIV_LAT : total EX-occupancy cycles of a mul/div op (2..16)
//   CNT_W      : perf counter width
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   rs1_D, rs2_D               : Decode source registers
//   rs1_E, rs2_E, rd_E         : Execute source/destination registers
//   rd_M, rd_W                 : Memory / Writeback destination registers
//   regWrite_M, regWrite_W     : Memory / Writeback write-enables
//   memRead_E                  : load in Execute
//   pcSrc_E                    : taken branch/jump resolved in Execute
//   muldiv_E                   : mul/div in Execute
//   stall_F/D/E                : hold stage register
//   flush_D/E/M                : load bubble into stage register
//   fwdA_E, fwdB_E             : 00 regfile, 01 Writeback, 10 Memory
//   muldiv_busy, muldiv_done   : mul/div sequencing status
//   stall, flush               : aggregate strobes (stall_F, flush_D)
//   stall_cnt, flush_cnt       : perf counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic [4:0]       rd_E,
    input  logic [4:0]       rd_M,
    input  logic [4:0]       rd_W,
    input  logic             regWrite_M,
    input  logic             regWrite_W,
    input  logic             memRead_E,
    input  logic             pcSrc_E,
    input  logic             muldiv_E,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic [1:0]       fwdA_E,
    output logic [1:0]       fwdB_E,
    output logic             muldiv_busy,
    output logic             muldiv_done,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int CNT_BITS = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
    // Accept cycle is the first stall; BUSY then stalls cnt more cycles and
    // spends one final cycle signalling done.
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MULDIV_LAT - 2);
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    logic                w_load_use;

    // Forward select for one EX operand; Memory result is newer than Writeback.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rdm,
        input logic       wr_w,
        input logic [4:0] rdw
    );
        logic [1:0] sel;
        if (wr_m && (rdm != 5'd0) && (rdm == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rdw != 5'd0) && (rdw == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign w_load_use = memRead_E && (rd_E != 5'd0) &&
                        ((rd_E == rs1_D) || (rd_E == rs2_D));

    assign fwdA_E = reset ? 2'b00 : fwd_sel(rs1_E, regWrite_M, rd_M, regWrite_W, rd_W);
    assign fwdB_E = reset ? 2'b00 : fwd_sel(rs2_E, regWrite_M, rd_M, regWrite_W, rd_W);

    assign muldiv_busy = (!reset) && (r_state == S_BUSY);
    assign stall       = stall_F;
    assign flush       = flush_D;

    // Hazard priority resolution and next-state logic for the mul/div hold.
    always_comb begin
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        stall_E     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        flush_M     = 1'b0;
        muldiv_done = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (reset) begin
            flush_D     = 1'b1;
            flush_E     = 1'b1;
            flush_M     = 1'b1;
            w_state_nxt = S_RUN;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (muldiv_E) begin
                        stall_F     = 1'b1;
                        stall_D     = 1'b1;
                        stall_E     = 1'b1;
                        flush_M     = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = S_BUSY;
                    end else if (pcSrc_E) begin
                        // Squashing D also discards any load-use it carried.
                        flush_D = 1'b1;
                        flush_E = 1'b1;
                    end else if (w_load_use) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_BUSY: begin
                    // EX-stage inputs still describe the held op; ignore them.
                    if (r_cnt != CNT_ZERO) begin
                        stall_F   = 1'b1;
                        stall_D   = 1'b1;
                        stall_E   = 1'b1;
                        flush_M   = 1'b1;
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end else begin
                        muldiv_done = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and mul/div down-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_flush_honoured;

    // A branch flush only counts when it actually won priority in RUN.
    assign w_flush_honoured = (!reset) && (r_state == S_RUN) && (!muldiv_E) && pcSrc_E;

    // Wrapping perf counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (stall_F) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush_honoured) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
